// File: rtl/main_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : main_mem_pkg
//  Description : Shared types and helpers for the main_mem_burst memory
//                model: FSM state encoding and a constant log2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package main_mem_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_BURST = 3'd2,
      WR_BURST = 3'd3,
      WR_WAIT  = 3'd4
   } state_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/main_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : main_mem_array
//  Description : Single-port synchronous RAM, 2**DEPTH_LOG2 words of DATA_W,
//                per-byte write enables, registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_mem_array
   import main_mem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic                     re,
   input  logic [DATA_W/BYTE_W-1:0] be,
   input  logic [DEPTH_LOG2-1:0]    addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   localparam int NB    = DATA_W / BYTE_W;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   // Byte-masked write; the array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Registered read; output holds its value between reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/main_mem_burst.sv
`default_nettype none
// ============================================================================
//  Module      : main_mem_burst
//  Description : Parametrised main-memory model with programmable latency and
//                critical-word-first wrapping line bursts. Separate read and
//                write channels, valid/ready request handshake.
//                Optional macro MAIN_MEM_WSTRB_EN adds the wr_strb byte-enable
//                port; without it every write beat writes the full word.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_mem_burst
   import main_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 5,
   parameter int BURST_LEN  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DATA_W-1:0]        wr_data,
`ifdef MAIN_MEM_WSTRB_EN
   input  logic [DATA_W/BYTE_W-1:0] wr_strb,
`endif
   output logic                     wr_done,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_last
);

   // Byte-offset bits of the address and the shared counter width.
   localparam int B      = clog2(DATA_W / BYTE_W);
   localparam int CNT_MAX = (LATENCY > BURST_LEN) ? LATENCY : BURST_LEN;
   localparam int CNT_W  = clog2(CNT_MAX) + 1;
   localparam logic [DEPTH_LOG2-1:0] BEAT_MASK = DEPTH_LOG2'(BURST_LEN - 1);

   state_t                    state, state_n;
   logic [CNT_W-1:0]          cnt, cnt_n;
   logic [DEPTH_LOG2-1:0]     word_idx;
   logic [DEPTH_LOG2-1:0]     beat_off;
   logic [DEPTH_LOG2-1:0]     mem_addr;
   logic [DATA_W/BYTE_W-1:0]  mem_be;
   logic                      mem_we, mem_re;
   logic                      accept;
   logic                      req_ready_n, wr_ready_n, rd_valid_n, rd_last_n, wr_done_n;
   logic                      unused_addr;

   // Only the word-index slice of the address matters; the rest aliases.
   assign unused_addr = ^req_addr;

`ifdef MAIN_MEM_WSTRB_EN
   assign mem_be = wr_strb;
`else
   assign mem_be = '1;
`endif

   // Wrap the beat offset inside the line, keeping the line base bits.
   assign mem_addr = (word_idx & ~BEAT_MASK) | ((word_idx + beat_off) & BEAT_MASK);

   // State, counter, latched address and registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         word_idx  <= '0;
         req_ready <= 1'b0;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         wr_done   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         req_ready <= req_ready_n;
         wr_ready  <= wr_ready_n;
         rd_valid  <= rd_valid_n;
         rd_last   <= rd_last_n;
         wr_done   <= wr_done_n;
         if (accept) begin
            word_idx <= req_addr[DEPTH_LOG2+B-1:B];
         end
      end
   end

   // Next-state logic; RAM reads are issued one cycle before each beat shows.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      accept     = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      beat_off   = '0;
      rd_valid_n = 1'b0;
      wr_done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               cnt_n   = '0;
               state_n = req_we ? WR_BURST : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (cnt == CNT_W'(LATENCY - 1)) begin
               mem_re     = 1'b1;
               rd_valid_n = 1'b1;
               cnt_n      = '0;
               state_n    = RD_BURST;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RD_BURST: begin
            beat_off = DEPTH_LOG2'(cnt) + DEPTH_LOG2'(1);
            if (cnt == CNT_W'(BURST_LEN - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               mem_re     = 1'b1;
               rd_valid_n = 1'b1;
               cnt_n      = cnt + 1'b1;
            end
         end
         WR_BURST: begin
            beat_off = DEPTH_LOG2'(cnt);
            if (wr_valid && wr_ready) begin
               mem_we = 1'b1;
               if (cnt == CNT_W'(BURST_LEN - 1)) begin
                  cnt_n   = '0;
                  state_n = WR_WAIT;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         WR_WAIT: begin
            if (cnt == CNT_W'(LATENCY - 1)) begin
               wr_done_n = 1'b1;
               cnt_n     = '0;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      req_ready_n = (state_n == IDLE);
      wr_ready_n  = (state_n == WR_BURST);
      rd_last_n   = rd_valid_n && (cnt_n == CNT_W'(BURST_LEN - 1));
   end

   main_mem_array #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .be    (mem_be),
      .addr  (mem_addr),
      .wdata (wr_data),
      .rdata (rd_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_main_mem_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_mem_burst
//  Description : Scoreboard bench for main_mem_burst (defaults: DATA_W=32,
//                LATENCY=5, BURST_LEN=4). Stimulus pushes expected read beats
//                and wr_done cycles; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_burst;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr;
   logic        wr_valid, wr_ready, wr_done;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        rd_valid, rd_last;
   logic [31:0] rd_data;

   int cyc = 0;
   int passed = 0;
   int total = 0;

   typedef struct {
      int          at;
      logic [31:0] data;
      logic        last;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   int      wr_q[$];
   rd_exp_t mon_e;
   int      mon_w;

   main_mem_burst dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
`ifdef MAIN_MEM_WSTRB_EN
      .wr_strb   (wr_strb),
`endif
      .wr_done   (wr_done),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Monitor: compare every presented read beat and wr_done pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (rd_valid) begin
            if (rd_q.size() == 0) begin
               check("rd_unexpected", 64'd1, 64'd0);
            end else begin
               mon_e = rd_q.pop_front();
               check("rd_cycle", 64'(mon_e.at), 64'(cyc));
               check("rd_data", 64'(rd_data), 64'(mon_e.data));
               check("rd_last", 64'(rd_last), 64'(mon_e.last));
            end
         end else if (rd_last) begin
            check("rd_last_without_valid", 64'd1, 64'd0);
         end
         if (wr_done) begin
            if (wr_q.size() == 0) begin
               check("wr_done_unexpected", 64'd1, 64'd0);
            end else begin
               mon_w = wr_q.pop_front();
               check("wr_done_cycle", 64'(cyc), 64'(mon_w));
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [31:0] addr, output int acc);
      @(negedge clk);
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic push_read(input int acc, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3, input int nbeats);
      logic [31:0] d [4];
      d = '{d0, d1, d2, d3};
      for (int k = 0; k < nbeats; k++) begin
         rd_q.push_back(rd_exp_t'{acc + 5 + k, d[k], (k == 3)});
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
      int acc;
      do_req(1'b0, addr, acc);
      push_read(acc, d0, d1, d2, d3, 4);
      repeat (12) @(negedge clk);
      check("rd_drained", 64'(rd_q.size()), 64'd0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input logic [15:0] strbs,
                           input logic [15:0] pat, input int plen);
      int acc;
      int beat;
      int done_at;
      logic [31:0] d [4];
      d = '{d0, d1, d2, d3};
      beat = 0;
      done_at = -1;
      do_req(1'b1, addr, acc);
      for (int i = 0; i < plen && beat < 4; i++) begin
         @(negedge clk);
         check("wr_ready_burst", 64'(wr_ready), 64'd1);
         wr_valid = pat[i];
         wr_data  = d[beat];
         wr_strb  = strbs[beat*4 +: 4];
         @(posedge clk);
         #1;
         if (wr_valid) begin
            beat++;
            if (beat == 4) done_at = cyc;
         end
         wr_valid = 1'b0;
      end
      check("wr_beats", 64'(beat), 64'd4);
      if (done_at >= 0) wr_q.push_back(done_at + 5);
      repeat (8) @(negedge clk);
      check("wr_done_seen", 64'(wr_q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      wr_strb   = '1;

      // 1. Reset state, request ignored during reset, async assertion.
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_last", 64'(rd_last), 64'd0);
      check("rst_wr_done", 64'(wr_done), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("req_ready_after_reset", 64'(req_ready), 64'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check("async_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // 2. Write line 0x40, read it back.
      do_write(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, 16'hFFFF, 16'h000F, 4);
      do_read(32'h40, 32'h11, 32'h22, 32'h33, 32'h44);

      // 3. Critical word first with wrap.
      do_read(32'h48, 32'h33, 32'h44, 32'h11, 32'h22);

      // 4. Address aliasing.
      do_write(32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 16'hFFFF, 16'h000F, 4);
      do_read(32'h4100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
      do_read(32'h1000_4100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

      // 5. Gapped write beats: valid pattern 1,0,0,1,1,0,1.
      do_write(32'h200, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 16'hFFFF, 16'h0059, 7);
      do_read(32'h200, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
`ifdef MAIN_MEM_WSTRB_EN
      do_write(32'h300, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 16'hFFFF, 16'h000F, 4);
      do_write(32'h300, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               16'h0005, 16'h000F, 4);
      do_read(32'h300, 32'h12FF_56FF, 32'h0, 32'h0, 32'h0);
`endif

      // 6. Reset after read beat 2, then a clean read with busy request probing.
      do_req(1'b0, 32'h40, acc);
      push_read(acc, 32'h11, 32'h22, 32'h33, 32'h44, 2);
      repeat (7) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_rd_valid", 64'(rd_valid), 64'd0);
      check("midrst_rd_last", 64'(rd_last), 64'd0);
      check("midrst_rd_data", 64'(rd_data), 64'd0);
      check("midrst_beats_seen", 64'(rd_q.size()), 64'd0);
      rd_q.delete();
      @(negedge clk);
      reset = 1'b0;
      do_req(1'b0, 32'h40, acc);
      push_read(acc, 32'h11, 32'h22, 32'h33, 32'h44, 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_we    = 1'b1;
         check("busy_req_ready", 64'(req_ready), 64'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'b0;
      repeat (10) @(negedge clk);
      check("rd_drained_final", 64'(rd_q.size()), 64'd0);
      check("idle_after_busy", 64'(req_ready), 64'd1);
      check("wr_q_empty", 64'(wr_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
